// File: rtl/router_reg_if.sv
// Handshake/data bundle between router_fsm, the input byte stream and router_reg.
// err_count exists only when ROUTER_REG_ERR_CNT_EN is defined.
interface router_reg_if #(
  parameter int WIDTH = 8
) ();
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             rst_int_reg;
  logic [WIDTH-1:0] dout;
  logic             parity_done;
  logic             low_packet_valid;
  logic             err;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0]       err_count;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, err_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, err_count
  );
`else
  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );
`endif
endinterface

// File: rtl/router_reg.sv
// 1x3 router datapath register: header/full-byte holding, output byte, running parity and error flag.
// Optional saturating error counter enabled by ROUTER_REG_ERR_CNT_EN.
module router_reg #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  router_reg_if.slave bus
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] header_byte, header_byte_d;
  logic [WIDTH-1:0] full_state_byte, full_state_byte_d;
  logic [WIDTH-1:0] internal_parity, internal_parity_d;
  logic [WIDTH-1:0] packet_parity, packet_parity_d;
  logic             parity_done_q, parity_done_d;
  logic             parity_done_prev;
  logic             low_packet_valid_q, low_packet_valid_d;
  logic             err_q, err_d;
  logic             hdr_invalid;
  logic             parity_from_ld;
  logic             parity_from_laf;

  always_comb begin
    dout_d             = dout_q;
    header_byte_d      = header_byte;
    full_state_byte_d  = full_state_byte;
    internal_parity_d  = internal_parity;
    packet_parity_d    = packet_parity;
    parity_done_d      = parity_done_q;
    low_packet_valid_d = low_packet_valid_q;
    err_d              = err_q;

    hdr_invalid     = bus.pkt_valid && (bus.data_in[1:0] == 2'b11);
    parity_from_ld  = bus.ld_state && !bus.pkt_valid && !bus.fifo_full;
    parity_from_laf = bus.laf_state && low_packet_valid_q && !parity_done_q;

    if (bus.detect_add && bus.pkt_valid && !hdr_invalid)
      header_byte_d = bus.data_in;

    if (bus.lfd_state)
      dout_d = header_byte;
    else if (bus.ld_state) begin
      if (!bus.fifo_full)
        dout_d = bus.data_in;
      else
        full_state_byte_d = bus.data_in;
    end else if (bus.laf_state)
      dout_d = full_state_byte;

    // An address-3 header leaves the running parity untouched rather than clearing it.
    if (bus.detect_add) begin
      if (!hdr_invalid)
        internal_parity_d = '0;
    end else if (bus.lfd_state)
      internal_parity_d = internal_parity ^ header_byte;
    else if (bus.ld_state && bus.pkt_valid && !bus.full_state && !bus.fifo_full)
      internal_parity_d = internal_parity ^ bus.data_in;

    if (bus.detect_add)
      parity_done_d = 1'b0;
    else if (parity_from_ld) begin
      packet_parity_d = bus.data_in;
      parity_done_d   = 1'b1;
    end else if (parity_from_laf) begin
      packet_parity_d = full_state_byte;
      parity_done_d   = 1'b1;
    end

    if (bus.ld_state && !bus.pkt_valid && bus.fifo_full)
      low_packet_valid_d = 1'b1;
    else if (bus.rst_int_reg)
      low_packet_valid_d = 1'b0;

    // Compare one cycle after parity_done rises so both parity registers have settled.
    if (bus.detect_add)
      err_d = 1'b0;
    else if (parity_done_q && !parity_done_prev)
      err_d = (internal_parity != packet_parity);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q             <= '0;
      header_byte        <= '0;
      full_state_byte    <= '0;
      internal_parity    <= '0;
      packet_parity      <= '0;
      parity_done_q      <= 1'b0;
      parity_done_prev   <= 1'b0;
      low_packet_valid_q <= 1'b0;
      err_q              <= 1'b0;
    end else begin
      dout_q             <= dout_d;
      header_byte        <= header_byte_d;
      full_state_byte    <= full_state_byte_d;
      internal_parity    <= internal_parity_d;
      packet_parity      <= packet_parity_d;
      parity_done_q      <= parity_done_d;
      parity_done_prev   <= parity_done_q;
      low_packet_valid_q <= low_packet_valid_d;
      err_q              <= err_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_packet_valid_q;
  assign bus.err              = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_count_q <= '0;
    else if (err_d && !err_q && (err_count_q != 8'hFF))
      err_count_q <= err_count_q + 8'd1;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed packets from the test plan plus randomized packets
// checked against a packet-level reference (expected bytes and header/payload parity).
module tb_router_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_reg_if #(.WIDTH(8)) bus ();

  router_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_dout;
  int         exp_cnt;
  logic [7:0] pay[$];
  bit         park[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic rir, input logic pv, input logic ff,
                       input logic [7:0] d);
    bus.detect_add  = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fs;
    bus.rst_int_reg = rir;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.data_in     = d;
  endtask

  // Drives one packet as the FSM would and checks it; payload/park flags come from pay/park.
  task automatic send_packet(input string tag, input logic [7:0] hdr, input logic [7:0] par,
                             input bit par_full);
    logic [7:0] exp_ip;
    bit         exp_err;
    exp_ip = hdr;
    foreach (pay[i]) if (!park[i]) exp_ip ^= pay[i];
    exp_err = (exp_ip != par);

    drive(1, 0, 0, 0, 0, 0, 1, 0, hdr); tick();
    n_total++;
    if (bus.parity_done !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL %s_decode pd=%b err=%b expected 0 0", tag, bus.parity_done, bus.err);
    else n_pass++;

    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom)); tick();
    exp_dout = hdr;
    n_total++;
    if (bus.dout !== exp_dout) $display("FAIL %s_lfd dout=%h expected %h", tag, bus.dout, exp_dout);
    else n_pass++;

    foreach (pay[i]) begin
      if (park[i]) begin
        drive(0, 0, 1, 0, 0, 0, 1, 1, pay[i]); tick();
        n_total++;
        if (bus.dout !== exp_dout) $display("FAIL %s_hold%0d dout=%h expected %h", tag, i, bus.dout, exp_dout);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1, 1, 8'($urandom)); tick();
        drive(0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom)); tick();
        exp_dout = pay[i];
        n_total++;
        if (bus.dout !== exp_dout) $display("FAIL %s_laf%0d dout=%h expected %h", tag, i, bus.dout, exp_dout);
        else n_pass++;
      end else begin
        drive(0, 0, 1, 0, 0, 0, 1, 0, pay[i]); tick();
        exp_dout = pay[i];
        n_total++;
        if (bus.dout !== exp_dout) $display("FAIL %s_ld%0d dout=%h expected %h", tag, i, bus.dout, exp_dout);
        else n_pass++;
      end
    end

    if (!par_full) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, par); tick();
      exp_dout = par;
      n_total++;
      if (bus.dout !== exp_dout || bus.parity_done !== 1'b1)
        $display("FAIL %s_par dout=%h pd=%b expected %h 1", tag, bus.dout, bus.parity_done, exp_dout);
      else n_pass++;
    end else begin
      drive(0, 0, 1, 0, 0, 0, 0, 1, par); tick();
      n_total++;
      if (bus.low_packet_valid !== 1'b1 || bus.parity_done !== 1'b0 || bus.dout !== exp_dout)
        $display("FAIL %s_parfull lpv=%b pd=%b dout=%h expected 1 0 %h", tag,
                 bus.low_packet_valid, bus.parity_done, bus.dout, exp_dout);
      else n_pass++;
      drive(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom)); tick();
      exp_dout = par;
      n_total++;
      if (bus.dout !== exp_dout || bus.parity_done !== 1'b1)
        $display("FAIL %s_parlaf dout=%h pd=%b expected %h 1", tag, bus.dout, bus.parity_done, exp_dout);
      else n_pass++;
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); tick();
    n_total++;
    if (bus.err !== exp_err || bus.parity_done !== 1'b1)
      $display("FAIL %s_err err=%b pd=%b expected %b 1", tag, bus.err, bus.parity_done, exp_err);
    else n_pass++;
`ifdef ROUTER_REG_ERR_CNT_EN
    if (exp_err && exp_cnt < 255) exp_cnt++;
    n_total++;
    if (bus.err_count !== 8'(exp_cnt))
      $display("FAIL %s_errcnt count=%0d expected %0d", tag, bus.err_count, exp_cnt);
    else n_pass++;
`endif

    if (par_full) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00); tick();
      n_total++;
      if (bus.low_packet_valid !== 1'b0)
        $display("FAIL %s_rir lpv=%b expected 0", tag, bus.low_packet_valid);
      else n_pass++;
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); tick();
    n_total++;
    if (bus.err !== exp_err) $display("FAIL %s_errhold err=%b expected %b", tag, bus.err, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    exp_dout = 8'h00;
    exp_cnt  = 0;
    n_total++;
    if (bus.dout !== 8'h00 || bus.parity_done !== 1'b0 || bus.low_packet_valid !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL reset dout=%h pd=%b lpv=%b err=%b expected 00 0 0 0",
               bus.dout, bus.parity_done, bus.low_packet_valid, bus.err);
    else n_pass++;
  endtask

  task automatic test_good_packet();
    pay = '{8'hA3}; park = '{1'b0};
    send_packet("good", 8'h05, 8'hA6, 1'b0);
  endtask

  task automatic test_bad_parity();
    pay = '{8'hA3}; park = '{1'b0};
    send_packet("bad", 8'h05, 8'h00, 1'b0);
  endtask

  task automatic test_fifo_full();
    pay = '{8'h3C, 8'h11}; park = '{1'b1, 1'b0};
    send_packet("full", 8'h09, 8'h11 ^ 8'h09, 1'b0);
  endtask

  task automatic test_parity_full();
    pay = '{8'hA3}; park = '{1'b0};
    send_packet("parfull", 8'h05, 8'hA6, 1'b1);
    send_packet("parfullbad", 8'h05, 8'h5A, 1'b1);
  endtask

  // After a 05/A3 packet the running parity is A6; an ignored address-3 header keeps it and
  // keeps header 05, so the next lfd adds 05 again giving A3.
  task automatic test_invalid_addr();
    pay = '{8'hA3}; park = '{1'b0};
    send_packet("pre_inv", 8'h05, 8'hA6, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h07); tick();
    n_total++;
    if (bus.parity_done !== 1'b0) $display("FAIL inv_decode pd=%b expected 0", bus.parity_done);
    else n_pass++;
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h00); tick();
    n_total++;
    if (bus.dout !== 8'h05) $display("FAIL inv_header dout=%h expected 05", bus.dout);
    else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 8'hA3); tick();
    n_total++;
    if (bus.dout !== 8'hA3 || bus.parity_done !== 1'b1)
      $display("FAIL inv_par dout=%h pd=%b expected a3 1", bus.dout, bus.parity_done);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); tick();
    n_total++;
    if (bus.err !== 1'b0) $display("FAIL inv_err err=%b expected 0", bus.err);
    else n_pass++;
    exp_dout = 8'hA3;
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h06); tick();
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h00); tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h77); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 1, 8'h12);
    rst = 1'b1; tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    exp_dout = 8'h00;
    exp_cnt  = 0;
    n_total++;
    if (bus.dout !== 8'h00 || bus.parity_done !== 1'b0 || bus.low_packet_valid !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL midreset dout=%h pd=%b lpv=%b err=%b expected 00 0 0 0",
               bus.dout, bus.parity_done, bus.low_packet_valid, bus.err);
    else n_pass++;
`ifdef ROUTER_REG_ERR_CNT_EN
    n_total++;
    if (bus.err_count !== 8'h00) $display("FAIL midreset_cnt count=%0d expected 0", bus.err_count);
    else n_pass++;
`endif
    pay = '{8'hA3}; park = '{1'b0};
    send_packet("after_rst", 8'h05, 8'hA6, 1'b0);
  endtask

  task automatic test_random_packets();
    for (int p = 0; p < 40; p++) begin
      logic [7:0] hdr;
      logic [7:0] par;
      int         len;
      len = int'($urandom_range(1, 6));
      hdr = {6'(len), 2'($urandom_range(0, 2))};
      pay.delete(); park.delete();
      par = hdr;
      for (int i = 0; i < len; i++) begin
        pay.push_back(8'($urandom));
        park.push_back(($urandom % 4) == 0);
        if (!park[i]) par ^= pay[i];
      end
      if ($urandom % 2 == 1) par = 8'($urandom);
      send_packet($sformatf("rnd%0d", p), hdr, par, ($urandom % 10) < 3);
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_parity_full();
    test_invalid_addr();
    test_reset_mid();
    test_random_packets();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
